// File: rtl/fetch_sequencer_if.sv
// Purpose: bundles the ROM port, the instruction handshake to the execution
//          unit, and the stack/fault status of the fetch sequencer.
// Signals:
//   rom_addr/rom_data           : asynchronous-read program ROM port
//   ir/ir_addr/ir_valid/ir_ready: instruction word handshake
//   br_req/br_type/br_target    : redirect reported with an accepted word
//   sp/fault/fault_code         : stack occupancy and sticky fault status
// Modports: master = sequencer side, slave = ROM / execution unit side.
interface fetch_sequencer_if #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_WIDTH  = 24,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_BITS = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_BITS-1:0]  rom_addr;
  logic [WORD_WIDTH-1:0] rom_data;
  logic [WORD_WIDTH-1:0] ir;
  logic [ADDR_BITS-1:0]  ir_addr;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  br_req;
  logic [1:0]            br_type;
  logic [ADDR_BITS-1:0]  br_target;
  logic [SP_BITS-1:0]    sp;
  logic                  fault;
  logic [1:0]            fault_code;

  modport master (
    output rom_addr, ir, ir_addr, ir_valid, sp, fault, fault_code,
    input  rom_data, ir_ready, br_req, br_type, br_target
  );

  modport slave (
    input  rom_addr, ir, ir_addr, ir_valid, sp, fault, fault_code,
    output rom_data, ir_ready, br_req, br_type, br_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: instruction-fetch controller. Owns the program counter and the
//          CLL/RET return-address stack, reads the async ROM and presents
//          each registered word over a valid/ready handshake, one per cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : fetch_sequencer_if.master (ROM port, handshake, redirects, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | first fetch after reset, ir not yet valid
// S_ISSUE | ir valid; each accept loads the next word in the same edge
// S_FAULT | stack overflow/underflow seen; frozen until reset
module fetch_sequencer #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_WIDTH  = 24,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  localparam int SP_BITS  = $clog2(STACK_DEPTH) + 1;
  localparam int PTR_BITS = $clog2(STACK_DEPTH);

  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_CLL = 2'b01;
  localparam logic [1:0] BR_RET = 2'b10;
  localparam logic [1:0] BR_RST = 2'b11;

  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_FAULT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_BITS-1:0]  r_pc;
  logic [WORD_WIDTH-1:0] r_ir;
  logic [ADDR_BITS-1:0]  r_ir_addr;
  logic                  r_ir_valid;
  logic [ADDR_BITS-1:0]  r_stack [STACK_DEPTH];
  logic [SP_BITS-1:0]    r_sp;
  logic                  r_fault;
  logic [1:0]            r_fault_code;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf;
  logic                  w_unf;
  logic [PTR_BITS-1:0]   w_top;
  logic [ADDR_BITS-1:0]  w_npc;
  logic [ADDR_BITS-1:0]  w_rom_addr;

  assign w_accept = (r_state == S_ISSUE) && r_ir_valid && bus.ir_ready;
  assign w_push   = w_accept && bus.br_req && (bus.br_type == BR_CLL);
  assign w_pop    = w_accept && bus.br_req && (bus.br_type == BR_RET);
  assign w_ovf    = w_push && (r_sp == SP_BITS'(STACK_DEPTH));
  assign w_unf    = w_pop && (r_sp == '0);
  assign w_top    = r_sp[PTR_BITS-1:0] - PTR_BITS'(1);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // next-state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH: w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_ovf || w_unf) w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // outputs: the ROM address follows the redirect combinationally so the
  // target word lands in ir on the same edge that accepts the branch.
  always_comb begin
    w_npc = r_pc;
    if (w_accept && bus.br_req) begin
      unique case (bus.br_type)
        BR_JMP, BR_CLL: w_npc = bus.br_target;
        BR_RET:         w_npc = r_stack[w_top];
        default:        w_npc = '0;
      endcase
    end
    w_rom_addr = r_pc;
    if (rst)           w_rom_addr = '0;
    else if (w_accept) w_rom_addr = w_npc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_ir_addr    <= '0;
      r_ir_valid   <= 1'b0;
      r_sp         <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else if (r_state == S_FETCH || (w_accept && !w_ovf && !w_unf)) begin
      r_ir       <= bus.rom_data;
      r_ir_addr  <= w_rom_addr;
      r_ir_valid <= 1'b1;
      r_pc       <= w_rom_addr + ADDR_BITS'(1);
      if (w_push)
        r_sp <= r_sp + SP_BITS'(1);
      else if (w_pop)
        r_sp <= r_sp - SP_BITS'(1);
      else if (w_accept && bus.br_req && bus.br_type == BR_RST)
        r_sp <= '0;
    end else if (w_ovf || w_unf) begin
      // faulting redirect: nothing fetched, stack untouched
      r_ir_valid   <= 1'b0;
      r_fault      <= 1'b1;
      r_fault_code <= w_ovf ? 2'b01 : 2'b10;
    end
  end

  // stack contents need no reset; sp alone defines what is live
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_ovf)
      r_stack[r_sp[PTR_BITS-1:0]] <= r_pc;
  end

  assign bus.rom_addr   = w_rom_addr;
  assign bus.ir         = r_ir;
  assign bus.ir_addr    = r_ir_addr;
  assign bus.ir_valid   = r_ir_valid;
  assign bus.sp         = r_sp;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: self-checking bench for fetch_sequencer. A random ROM image and a
//          transaction-level model (queue for the return stack) predict every
//          handshake result; directed sequences hit the boundary cases and a
//          random phase follows.
module tb_fetch_sequencer;
  localparam int AB = 8;
  localparam int WW = 24;
  localparam int SD = 8;

  logic clk;
  logic rst;
  logic [WW-1:0] mem [256];

  fetch_sequencer_if #(.ADDR_BITS(AB), .WORD_WIDTH(WW), .STACK_DEPTH(SD)) bus ();

  fetch_sequencer #(.ADDR_BITS(AB), .WORD_WIDTH(WW), .STACK_DEPTH(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_data = mem[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit       m_valid;
  bit       m_fault;
  int       m_code;
  int       m_addr;
  int       m_ir;
  int       m_next;
  int       m_stack[$];
  int       fault_age;

  // stimulus copies
  bit       t_rst, t_rdy, t_br;
  int       t_type, t_tgt;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int tgt;
    if (t_rst) begin
      m_valid = 0; m_fault = 0; m_code = 0;
      m_addr = 0; m_ir = 0; m_next = 0;
      m_stack.delete();
    end else if (m_fault) begin
      // frozen until reset
    end else if (!m_valid) begin
      m_addr  = m_next;
      m_ir    = int'(mem[m_addr]);
      m_next  = (m_addr + 1) % 256;
      m_valid = 1;
    end else if (t_rdy) begin
      tgt = m_next;
      if (t_br) begin
        case (t_type)
          0: tgt = t_tgt;
          1: if (m_stack.size() == SD) begin m_fault = 1; m_code = 1; end
             else begin m_stack.push_back(m_next); tgt = t_tgt; end
          2: if (m_stack.size() == 0) begin m_fault = 1; m_code = 2; end
             else tgt = m_stack.pop_back();
          default: begin m_stack.delete(); tgt = 0; end
        endcase
      end
      if (m_fault) m_valid = 0;
      else begin
        m_addr = tgt;
        m_ir   = int'(mem[tgt]);
        m_next = (tgt + 1) % 256;
      end
    end
  endtask

  task automatic compare();
    check("ir_valid", int'(bus.ir_valid), int'(m_valid));
    check("ir_addr", int'(bus.ir_addr), m_addr);
    check("ir", int'(bus.ir), m_ir);
    check("sp", int'(bus.sp), m_stack.size());
    check("fault", int'(bus.fault), int'(m_fault));
    check("fault_code", int'(bus.fault_code), m_code);
  endtask

  // one clock: drive inputs, check rom_addr where the model knows it,
  // step the model on the edge, compare on the falling edge
  task automatic step(input bit r, input bit rdy, input bit br,
                      input int typ, input int tgt);
    t_rst = r; t_rdy = rdy; t_br = br; t_type = typ; t_tgt = tgt;
    rst           = r;
    bus.ir_ready  = rdy;
    bus.br_req    = br;
    bus.br_type   = 2'(typ);
    bus.br_target = 8'(tgt);
    #1;
    if (r)
      check("rom_addr_rst", int'(bus.rom_addr), 0);
    else if (m_fault || !m_valid || !rdy || !br)
      check("rom_addr", int'(bus.rom_addr), m_next);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic reset_seq();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 5);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = WW'($urandom);
    rst = 1'b1;
    bus.ir_ready = 1'b0; bus.br_req = 1'b0; bus.br_type = 2'b00; bus.br_target = '0;
    @(negedge clk);

    // reset, first fetch, sequential issue and backpressure at ir_addr 2
    reset_seq();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 99);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // JMP 8, CLL 20, JMP 25, RET -> 9, then 10, JMP 4
    step(0, 1, 1, 0, 8);
    step(0, 1, 1, 1, 20);
    step(0, 1, 1, 0, 25);
    step(0, 1, 1, 2, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 4);

    // nested calls until overflow, inputs ignored in fault, recovery
    reset_seq();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 30 + i);
    for (int i = 0; i < 3; i++) step(0, 1, 1, $urandom_range(3), $urandom_range(255));
    reset_seq();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // underflow
    reset_seq();
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 0, 0, 0);

    // soft restart at sp 3
    reset_seq();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 60 + 10 * i);
    step(0, 1, 1, 3, 77);
    step(0, 1, 0, 0, 0);

    // address wrap 253..255 -> 0
    step(0, 1, 1, 0, 253);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

    // reset mid-handshake with a redirect pending
    step(0, 0, 1, 0, 77);
    step(1, 0, 1, 0, 77);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // random phase
    fault_age = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r;
      fault_age = m_fault ? fault_age + 1 : 0;
      r = ($urandom_range(99) == 0) || (fault_age > 4);
      step(r, $urandom_range(9) < 7, $urandom_range(3) == 0,
           $urandom_range(3), $urandom_range(255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the program ROM. It owns the program counter and the CLL/RET return-address stack, and drives the ROM address. Each 24-bit word (8-bit opcode, 16-bit operand) read from the combinational-read ROM is registered and presented to the execution unit over a valid/ready handshake. The execution unit reports JMP/JMA-taken/CLL/RET/RST redirects back to this block when it accepts the corresponding instruction.

## Interface
- ADDR_BITS, 8, ROM address width; PC width
- WORD_WIDTH, 24, instruction word width
- STACK_DEPTH, 8, return-address stack entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- rom_addr  out  ADDR_BITS  address to ROM (combinational, see Operation)
- rom_data  in  WORD_WIDTH  ROM read data, valid in the same cycle as rom_addr
- ir  out  WORD_WIDTH  registered instruction word
- ir_addr  out  ADDR_BITS  ROM address `ir` was fetched from
- ir_valid  out  1  `ir` holds an unconsumed instruction
- ir_ready  in  1  execution unit accepts `ir` this cycle
- br_req  in  1  redirect request; qualified by ir_valid&&ir_ready
- br_type  in  2  00 JMP, 01 CLL, 10 RET, 11 RST (soft restart)
- br_target  in  ADDR_BITS  target for JMP/CLL; ignored for RET/RST
- sp  out  log2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH
- fault  out  1  sticky: stack overflow or underflow
- fault_code  out  2  01 overflow, 10 underflow, 00 none

## Operation
- Registers: pc (next fetch address), ir, ir_addr, ir_valid, stack[STACK_DEPTH], sp, state, fault, fault_code.
- States: FETCH, ISSUE, FAULT.
- accept = state==ISSUE && ir_valid && ir_ready.
- npc: if accept&&br_req: JMP/CLL→br_target, RET→stack[sp-1], RST→0; else pc.
- rom_addr = (state==FETCH) ? pc : (accept ? npc : pc).
- FETCH: ir←rom_data, ir_addr←rom_addr, ir_valid←1, pc←rom_addr+1, go ISSUE.
- ISSUE without accept: all registers hold. ir is stable while ir_valid && !ir_ready.
- ISSUE with accept: ir←rom_data, ir_addr←rom_addr, pc←rom_addr+1, ir_valid stays 1. Throughput is one instruction per cycle.
- CLL on accept: stack[sp]←pc (the address after the CLL), sp←sp+1. If sp==STACK_DEPTH, this is overflow.
- RET on accept: sp←sp-1, target=stack[sp-1]. If sp==0, this is underflow.
- RST on accept: pc path to 0, sp←0, stack contents don't-care.
- Overflow or underflow: no fetch, no stack change, ir_valid←0, fault←1, fault_code set, go FAULT.
- FAULT: holds until rst. ir_valid=0. rom_addr=pc. br_req and ir_ready are ignored.
- br_req without accept is ignored entirely.
- PC arithmetic is modulo 2^ADDR_BITS: 255+1→0 with no flag.
- A JMA that is not taken is reported as no br_req.

## Timing
- Reset values: pc=0, ir=0, ir_addr=0, ir_valid=0, sp=0, fault=0, fault_code=00, state=FETCH. rom_addr=0 during the reset cycle.
- rst has priority over every other input in the same cycle, including mid-handshake and in FAULT.
- First instruction: rst high at edge N, low after. mem[0] is in ir with ir_valid=1 after edge N+1.
- Redirect latency: redirect accepted at edge K. Target word is in ir after edge K, with no bubble and no squash needed.
- Combinational path ir_ready/br_* → rom_addr → rom_data → ir D input: the ROM must be asynchronous-read.
- Push and pop never occur in the same cycle (single redirect per accept).

## Test plan
- Reset then ir_ready=1 constant, no br_req → ir_addr 0,1,2,3 on consecutive cycles; ir = mem[0..3]. ir_valid rises exactly one cycle after rst falls.
- Backpressure: ir_ready=0 for 3 cycles at ir_addr=2 → ir, ir_addr, pc, rom_addr=3 frozen. On release, ir_addr=3 on the next cycle.
- CLL at ir_addr=8, br_target=20 → next ir_addr=20, sp=1, stack[0]=9. RET at ir_addr=25 → next ir_addr=9, sp=0. JMP at 10 to 4 → next ir_addr=4.
- STACK_DEPTH=8, nine nested CLLs → sp reaches 8. Ninth CLL → fault=1, fault_code=01, ir_valid=0, sp=8. Stays there until rst, then normal fetch from 0.
- RET with sp=0 → fault_code=10, ir_valid=0. RST redirect at sp=3 → ir_addr=0, sp=0.
- Sequential fetch through 254,255 → ir_addr wraps to 0 with no fault. rst asserted while ir_valid=1 && ir_ready=0 with br_req pending → all reset values next cycle, branch discarded.
